// File: rtl/k054539_pkg.sv
// Shared definitions for the 054539 host interface and its register file.
// Register-map addresses are internal {AB09, AB[7:0]} values (host AB8 is not bonded).
package k054539_pkg;

    localparam int unsigned HOST_ADDR_W     = 9;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned ACK_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_HOLD
    } host_state_t;

    localparam logic [HOST_ADDR_W-1:0] REG_CH_BASE   = 9'h000;
    localparam logic [HOST_ADDR_W-1:0] REG_CTRL_BASE = 9'h100;
    localparam logic [HOST_ADDR_W-1:0] REG_ROM_ADDR  = 9'h12A;
    localparam logic [HOST_ADDR_W-1:0] REG_ROM_DATA  = 9'h12D;

endpackage

// File: rtl/k054539_sync.sv
// Multi-flop synchroniser with registered-edge detection; reset loads RST_VAL into
// every stage so no spurious edge appears when reset releases.
module k054539_sync #(
    parameter int unsigned      STAGES  = 2,
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
)(
    input  logic             i_clk,
    input  logic             i_nres,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_pipe [STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_nres) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_pipe[i] <= RST_VAL;
            end
            r_prev <= RST_VAL;
        end else begin
            r_pipe[0] <= i_d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_prev <= r_pipe[STAGES-1];
        end
    end

    assign o_q    = r_pipe[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/k054539_host_if.sv
// Host-bus responder for the 054539: synchronised CPU strobes become register-file
// write pulses and a read handshake. Optional macro K054539_HOSTIF_WAIT_EN enables PIN_WAIT.
module k054539_host_if
    import k054539_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int unsigned ADDR_W      = HOST_ADDR_W
)(
    input  logic              CLK,
    input  logic              NRES,
    input  logic [7:0]        PIN_AB,
    input  logic              PIN_AB09,
    input  logic [7:0]        PIN_DB_IN,
    output logic [7:0]        PIN_DB_OUT,
    output logic              PIN_DB_OE,
    input  logic              PIN_NCS,
    input  logic              PIN_NRD,
    input  logic              PIN_NWR,
    output logic              PIN_WAIT,
    output logic [ADDR_W-1:0] RW_ADDR,
    output logic [7:0]        RW_WDATA,
    output logic              RW_WE,
    output logic              RW_RE,
    input  logic [7:0]        RW_RDATA,
    input  logic              RW_ACK
);

    localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic w_ncs, w_ncs_rise, w_ncs_unused_fall;
    logic w_nrd, w_nrd_fall, w_nrd_unused_rise;
    logic w_nwr, w_nwr_rise, w_nwr_fall;
    logic [16:0] w_bus, w_bus_unused_rise, w_bus_unused_fall;

    // Bus pipe has the same depth as the strobe pipes, so address/data line up with the edges.
    k054539_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_ncs (
        .i_clk(CLK), .i_nres(NRES), .i_d(PIN_NCS),
        .o_q(w_ncs), .o_rise(w_ncs_rise), .o_fall(w_ncs_unused_fall)
    );
    k054539_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_nrd (
        .i_clk(CLK), .i_nres(NRES), .i_d(PIN_NRD),
        .o_q(w_nrd), .o_rise(w_nrd_unused_rise), .o_fall(w_nrd_fall)
    );
    k054539_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_nwr (
        .i_clk(CLK), .i_nres(NRES), .i_d(PIN_NWR),
        .o_q(w_nwr), .o_rise(w_nwr_rise), .o_fall(w_nwr_fall)
    );
    k054539_sync #(.STAGES(SYNC_STAGES), .WIDTH(17), .RST_VAL('0)) u_sync_bus (
        .i_clk(CLK), .i_nres(NRES), .i_d({PIN_AB09, PIN_AB, PIN_DB_IN}),
        .o_q(w_bus), .o_rise(w_bus_unused_rise), .o_fall(w_bus_unused_fall)
    );

    logic              w_cs;
    logic [ADDR_W-1:0] w_bus_addr;
    logic [7:0]        w_bus_data;

    assign w_cs       = ~w_ncs;
    assign w_bus_addr = ADDR_W'(w_bus[16:8]);
    assign w_bus_data = w_bus[7:0];

    host_state_t       r_state, w_nxt_state;
    logic [ADDR_W-1:0] r_addr, w_nxt_addr;
    logic [7:0]        r_wdata, w_nxt_wdata;
    logic [7:0]        r_dbout, w_nxt_dbout;
    logic              r_we, w_nxt_we;
    logic              r_re, w_nxt_re;
    logic              r_dboe, w_nxt_dboe;
    logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;

    always_ff @(posedge CLK) begin
        if (!NRES) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dbout <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_dboe  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
            r_dbout <= w_nxt_dbout;
            r_we    <= w_nxt_we;
            r_re    <= w_nxt_re;
            r_dboe  <= w_nxt_dboe;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;
        w_nxt_dbout = r_dbout;
        w_nxt_we    = 1'b0;
        w_nxt_re    = r_re;
        w_nxt_dboe  = r_dboe;
        w_nxt_cnt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs && w_nwr_fall && w_nrd) begin
                    w_nxt_state = ST_WR;
                    w_nxt_addr  = w_bus_addr;
                    w_nxt_wdata = w_bus_data;
                end else if (w_cs && w_nrd_fall && w_nwr) begin
                    w_nxt_state = ST_RD;
                    w_nxt_addr  = w_bus_addr;
                    w_nxt_re    = 1'b1;
                    w_nxt_cnt   = '0;
                end
            end
            ST_WR: begin
                // A rising NCS on this same sample still means CS was low on the previous one.
                if (w_nwr_rise && (w_cs || w_ncs_rise)) begin
                    w_nxt_we    = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else if (!w_cs || !w_nrd) begin
                    w_nxt_state = ST_IDLE;
                end else if (!w_nwr) begin
                    w_nxt_addr  = w_bus_addr;
                    w_nxt_wdata = w_bus_data;
                end
            end
            ST_RD: begin
                if (!w_cs || w_nrd) begin
                    w_nxt_re    = 1'b0;
                    w_nxt_state = ST_IDLE;
                end else if (RW_ACK) begin
                    w_nxt_dbout = RW_RDATA;
                    w_nxt_re    = 1'b0;
                    w_nxt_dboe  = 1'b1;
                    w_nxt_state = ST_HOLD;
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt_dbout = 8'hFF;
                    w_nxt_re    = 1'b0;
                    w_nxt_dboe  = 1'b1;
                    w_nxt_state = ST_HOLD;
                end else if (r_cnt != '1) begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_cs || w_nrd) begin
                    w_nxt_dboe  = 1'b0;
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign RW_ADDR    = r_addr;
    assign RW_WDATA   = r_wdata;
    assign RW_WE      = r_we;
    assign RW_RE      = r_re;
    assign PIN_DB_OUT = r_dbout;
    assign PIN_DB_OE  = r_dboe;

`ifdef K054539_HOSTIF_WAIT_EN
    // WAIT spans exactly the outstanding read request, so it shares the RE flop.
    assign PIN_WAIT = r_re;
`else
    assign PIN_WAIT = 1'b0;
`endif

endmodule

// File: tb/tb_k054539_host_if.sv
// Scoreboard bench for k054539_host_if: stimulus queues expected events, a negedge
// monitor pops and compares whenever the DUT presents a write, read request or read result.
module tb_k054539_host_if;
    import k054539_pkg::*;

    localparam int SYNC = 2;
    localparam int TMO  = 15;
`ifdef K054539_HOSTIF_WAIT_EN
    localparam int WAIT_ON = 1;
`else
    localparam int WAIT_ON = 0;
`endif
    localparam int EV_WR = 0;
    localparam int EV_RE = 1;
    localparam int EV_RD = 2;

    logic       CLK = 1'b0;
    logic       NRES = 1'b0;
    logic [7:0] PIN_AB = '0, PIN_DB_IN = '0, RW_RDATA = '0;
    logic       PIN_AB09 = 1'b0, PIN_NCS = 1'b1, PIN_NRD = 1'b1, PIN_NWR = 1'b1, RW_ACK = 1'b0;
    logic [7:0] PIN_DB_OUT, RW_WDATA;
    logic       PIN_DB_OE, PIN_WAIT, RW_WE, RW_RE;
    logic [8:0] RW_ADDR;

    always #5 CLK = ~CLK;

    k054539_host_if #(.SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO), .ADDR_W(9)) dut (
        .CLK(CLK), .NRES(NRES), .PIN_AB(PIN_AB), .PIN_AB09(PIN_AB09),
        .PIN_DB_IN(PIN_DB_IN), .PIN_DB_OUT(PIN_DB_OUT), .PIN_DB_OE(PIN_DB_OE),
        .PIN_NCS(PIN_NCS), .PIN_NRD(PIN_NRD), .PIN_NWR(PIN_NWR), .PIN_WAIT(PIN_WAIT),
        .RW_ADDR(RW_ADDR), .RW_WDATA(RW_WDATA), .RW_WE(RW_WE), .RW_RE(RW_RE),
        .RW_RDATA(RW_RDATA), .RW_ACK(RW_ACK)
    );

    typedef struct {
        int kind;
        int addr;
        int data;
        int re_cyc;
        int wait_cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Monitor state
    logic prev_re = 1'b0, prev_oe = 1'b0;
    int   re_cyc = 0, wait_cyc = 0;

    function automatic void take(int kind, int a, int d);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: actual kind=%0d addr=0x%0h data=0x%0h required=none", kind, a, d);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_WR) begin
                chk("wr_addr", a, e.addr);
                chk("wr_data", d, e.data);
            end else if (kind == EV_RE) begin
                chk("re_addr", a, e.addr);
            end else begin
                chk("rd_dout", d, e.data);
                chk("re_cycles", re_cyc, e.re_cyc);
                chk("wait_cycles", wait_cyc, e.wait_cyc);
            end
        end
    endfunction

    always @(negedge CLK) begin
        if (!NRES) begin
            prev_re  = 1'b0;
            prev_oe  = 1'b0;
            re_cyc   = 0;
            wait_cyc = 0;
        end else begin
            if (RW_WE) take(EV_WR, int'(RW_ADDR), int'(RW_WDATA));
            if (RW_RE) begin
                if (!prev_re) begin
                    re_cyc   = 0;
                    wait_cyc = 0;
                    take(EV_RE, int'(RW_ADDR), 0);
                end
                re_cyc++;
            end
            if (PIN_WAIT) wait_cyc++;
            if (PIN_DB_OE && !prev_oe) take(EV_RD, 0, int'(PIN_DB_OUT));
            prev_re = RW_RE;
            prev_oe = PIN_DB_OE;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_re(input string name);
        int n = 0;
        while (!RW_RE && n < 20) begin
            tick(1);
            n++;
        end
        chk(name, int'(RW_RE), 1);
    endtask

    task automatic host_write(input logic [9:0] ha, input logic [7:0] d, input logic [8:0] exp_addr);
        q.push_back('{EV_WR, int'(exp_addr), int'(d), 0, 0});
        PIN_AB    = ha[7:0];
        PIN_AB09  = ha[9];
        PIN_DB_IN = d;
        PIN_NCS   = 1'b0;
        tick(2);
        PIN_NWR = 1'b0;
        tick(3);
        PIN_NWR = 1'b1;
        tick(2);
        PIN_NCS = 1'b1;
        tick(6);
    endtask

    // ack_dly < 0 means the backend never acknowledges
    task automatic host_read(input logic [9:0] ha, input logic [8:0] exp_addr, input int ack_dly,
                             input logic [7:0] rdata, input logic [7:0] exp_dout, input int exp_re);
        int n;
        q.push_back('{EV_RE, int'(exp_addr), 0, 0, 0});
        q.push_back('{EV_RD, 0, int'(exp_dout), exp_re, WAIT_ON * exp_re});
        PIN_AB   = ha[7:0];
        PIN_AB09 = ha[9];
        PIN_NCS  = 1'b0;
        tick(2);
        PIN_NRD = 1'b0;
        wait_re("rd_re_seen");
        if (ack_dly >= 0) begin
            tick(ack_dly);
            RW_RDATA = rdata;
            RW_ACK   = 1'b1;
            tick(1);
            RW_ACK   = 1'b0;
            RW_RDATA = 8'h00;
        end
        n = 0;
        while (!PIN_DB_OE && n < 40) begin
            tick(1);
            n++;
        end
        chk("rd_oe_seen", int'(PIN_DB_OE), 1);
        tick(3);
        chk("rd_oe_held", int'(PIN_DB_OE), 1);
        chk("rd_dout_held", int'(PIN_DB_OUT), int'(exp_dout));
        chk("rd_wait_low_in_hold", int'(PIN_WAIT), 0);
        PIN_NRD = 1'b1;
        tick(SYNC + 2);
        chk("rd_oe_released", int'(PIN_DB_OE), 0);
        PIN_NCS = 1'b1;
        tick(4);
    endtask

    task automatic drain(input string name);
        tick(4);
        chk(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        tick(4);
        chk("rst_addr", int'(RW_ADDR), 0);
        chk("rst_wdata", int'(RW_WDATA), 0);
        chk("rst_we", int'(RW_WE), 0);
        chk("rst_re", int'(RW_RE), 0);
        chk("rst_wait", int'(PIN_WAIT), 0);
        chk("rst_dbout", int'(PIN_DB_OUT), 0);
        chk("rst_dboe", int'(PIN_DB_OE), 0);
        NRES = 1'b1;
        tick(3);

        // single write
        host_write(10'h050, 8'h11, 9'h050);
        drain("t1_drain");

        // back-to-back writes, AB8 not bonded
        host_write(10'h210, 8'h55, 9'h110);
        host_write(10'h051, 8'h22, 9'h051);
        drain("t2_drain");

        // read acknowledged 3 cycles after RE
        host_read(10'h22D, 9'h12D, 3, 8'hA5, 8'hA5, 4);
        drain("t3_drain");

        // read with no acknowledge
        host_read(10'h22D, 9'h12D, -1, 8'h00, 8'hFF, TMO);
        drain("t4_drain");

        // NRD and NWR low together: no access
        PIN_AB  = 8'h33;
        PIN_NCS = 1'b0;
        tick(2);
        PIN_NRD = 1'b0;
        PIN_NWR = 1'b0;
        tick(6);
        chk("t5_dboe", int'(PIN_DB_OE), 0);
        chk("t5_re", int'(RW_RE), 0);
        PIN_NRD = 1'b1;
        PIN_NWR = 1'b1;
        tick(2);
        PIN_NCS = 1'b1;
        drain("t5_drain");

        // NCS rises before NWR: write aborted
        PIN_AB    = 8'h44;
        PIN_DB_IN = 8'h99;
        PIN_NCS   = 1'b0;
        tick(2);
        PIN_NWR = 1'b0;
        tick(3);
        PIN_NCS = 1'b1;
        tick(3);
        PIN_NWR = 1'b1;
        drain("abort_drain");

        // reset mid-read
        q.push_back('{EV_RE, 'h051, 0, 0, 0});
        PIN_AB   = 8'h51;
        PIN_AB09 = 1'b0;
        PIN_NCS  = 1'b0;
        tick(2);
        PIN_NRD = 1'b0;
        wait_re("t6_re_seen");
        tick(2);
        NRES    = 1'b0;
        PIN_NRD = 1'b1;
        PIN_NCS = 1'b1;
        tick(1);
        chk("t6_re_after_rst", int'(RW_RE), 0);
        chk("t6_wait_after_rst", int'(PIN_WAIT), 0);
        chk("t6_dboe_after_rst", int'(PIN_DB_OE), 0);
        tick(2);
        NRES = 1'b1;
        tick(4);
        RW_RDATA = 8'h3C;
        RW_ACK   = 1'b1;
        tick(2);
        RW_ACK   = 1'b0;
        tick(4);
        chk("t6_dbout_late_ack", int'(PIN_DB_OUT), 0);
        chk("t6_dboe_late_ack", int'(PIN_DB_OE), 0);
        chk("t6_re_late_ack", int'(RW_RE), 0);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
